// File: rtl/combat_resolver.sv
// Resolves hits vs. blocks, health, stun, round timer and winner for two players on the game clock.
// Latency: every output is registered and reflects the inputs sampled at that edge; no backpressure.
module combat_resolver #(
  parameter logic [2:0] MAX_HEALTH     = 3'd3,
  parameter logic [2:0] DMG_BASIC      = 3'd1,
  parameter logic [2:0] DMG_DIR        = 3'd2,
  parameter logic [9:0] REACH_BASIC    = 10'd32,
  parameter logic [9:0] REACH_DIR      = 10'd48,
  parameter logic [9:0] SPRITE_W       = 10'd64,
  parameter logic [4:0] HITSTUN        = 5'd16,
  parameter logic [4:0] BLOCKSTUN      = 5'd8,
  parameter logic [6:0] TIME_LIMIT     = 7'd99,
  parameter logic [5:0] FRAMES_PER_SEC = 6'd60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [9:0] p1_x,
  input  logic [9:0] p2_x,
  input  logic [3:0] p1_state,
  input  logic [3:0] p2_state,
  input  logic       p1_attacking,
  input  logic       p1_dir_attacking,
  input  logic       p2_attacking,
  input  logic       p2_dir_attacking,
  output logic       play_active,
  output logic [2:0] p1_health,
  output logic [2:0] p2_health,
  output logic       p1_hitstun,
  output logic       p1_blockstun,
  output logic       p2_hitstun,
  output logic       p2_blockstun,
  output logic [6:0] round_time,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {S_READY, S_PLAY, S_OVER} state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_p1_hs_cnt, r_p1_bs_cnt, r_p2_hs_cnt, r_p2_bs_cnt;
  logic [4:0]  w_p1_hs_nxt, w_p1_bs_nxt, w_p2_hs_nxt, w_p2_bs_nxt;
  logic        r_p1_latch, r_p2_latch;
  logic [5:0]  r_presc, w_presc_nxt;
  logic [6:0]  w_time_nxt;
  logic [2:0]  w_p1_health_nxt, w_p2_health_nxt, w_p1_dmg, w_p2_dmg;
  logic [1:0]  w_winner_nxt;
  logic [10:0] w_p1_right, w_gap, w_p1_reach, w_p2_reach;
  logic        w_play, w_p1_hit, w_p2_hit, w_p1_block, w_p2_block, w_wrap;

  // Overlapping sprites count as zero gap rather than wrapping negative.
  assign w_p1_right = {1'b0, p1_x} + {1'b0, SPRITE_W};
  assign w_gap      = ({1'b0, p2_x} < w_p1_right) ? 11'd0 : ({1'b0, p2_x} - w_p1_right);

  assign w_play     = (r_state == S_PLAY);
  assign w_p1_reach = {1'b0, (p1_dir_attacking ? REACH_DIR : REACH_BASIC)};
  assign w_p2_reach = {1'b0, (p2_dir_attacking ? REACH_DIR : REACH_BASIC)};
  assign w_p1_dmg   = p1_dir_attacking ? DMG_DIR : DMG_BASIC;
  assign w_p2_dmg   = p2_dir_attacking ? DMG_DIR : DMG_BASIC;
  assign w_p1_hit   = w_play && (p1_state == 4'd6) && !r_p1_latch &&
                      (p1_attacking || p1_dir_attacking) && (w_gap <= w_p1_reach);
  assign w_p2_hit   = w_play && (p2_state == 4'd6) && !r_p2_latch &&
                      (p2_attacking || p2_dir_attacking) && (w_gap <= w_p2_reach);
  assign w_p1_block = (p1_state == 4'd2) && !p1_hitstun;
  assign w_p2_block = (p2_state == 4'd2) && !p2_hitstun;

  always_comb begin
    w_p1_health_nxt = p1_health;
    w_p2_health_nxt = p2_health;
    w_p1_hs_nxt     = (r_p1_hs_cnt != 5'd0) ? r_p1_hs_cnt - 5'd1 : 5'd0;
    w_p1_bs_nxt     = (r_p1_bs_cnt != 5'd0) ? r_p1_bs_cnt - 5'd1 : 5'd0;
    w_p2_hs_nxt     = (r_p2_hs_cnt != 5'd0) ? r_p2_hs_cnt - 5'd1 : 5'd0;
    w_p2_bs_nxt     = (r_p2_bs_cnt != 5'd0) ? r_p2_bs_cnt - 5'd1 : 5'd0;
    if (w_p1_hit) begin
      if (w_p2_block) begin
        w_p2_bs_nxt = BLOCKSTUN;
      end else begin
        w_p2_health_nxt = (p2_health > w_p1_dmg) ? p2_health - w_p1_dmg : 3'd0;
        w_p2_hs_nxt     = HITSTUN;
        w_p2_bs_nxt     = 5'd0;
      end
    end
    if (w_p2_hit) begin
      if (w_p1_block) begin
        w_p1_bs_nxt = BLOCKSTUN;
      end else begin
        w_p1_health_nxt = (p1_health > w_p2_dmg) ? p1_health - w_p2_dmg : 3'd0;
        w_p1_hs_nxt     = HITSTUN;
        w_p1_bs_nxt     = 5'd0;
      end
    end
  end

  assign w_wrap      = (r_presc == FRAMES_PER_SEC - 6'd1);
  assign w_presc_nxt = w_wrap ? 6'd0 : r_presc + 6'd1;
  assign w_time_nxt  = (w_wrap && round_time != 7'd0) ? round_time - 7'd1 : round_time;

  // KO is checked before timeout so a simultaneous expiry still reports the knockout.
  always_comb begin
    w_state_nxt  = r_state;
    w_winner_nxt = winner;
    case (r_state)
      S_READY: if (start) w_state_nxt = S_PLAY;
      S_PLAY: begin
        if (w_p1_health_nxt == 3'd0 || w_p2_health_nxt == 3'd0) begin
          w_state_nxt = S_OVER;
          if (w_p1_health_nxt == 3'd0 && w_p2_health_nxt == 3'd0) w_winner_nxt = 2'b11;
          else if (w_p2_health_nxt == 3'd0)                       w_winner_nxt = 2'b01;
          else                                                     w_winner_nxt = 2'b10;
        end else if (w_time_nxt == 7'd0) begin
          w_state_nxt = S_OVER;
          if (w_p1_health_nxt > w_p2_health_nxt)      w_winner_nxt = 2'b01;
          else if (w_p2_health_nxt > w_p1_health_nxt) w_winner_nxt = 2'b10;
          else                                         w_winner_nxt = 2'b11;
        end
      end
      S_OVER:  if (start) w_state_nxt = S_READY;
      default: w_state_nxt = S_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_READY;
      play_active  <= 1'b0;
      game_over    <= 1'b0;
      winner       <= 2'b00;
      p1_health    <= MAX_HEALTH;
      p2_health    <= MAX_HEALTH;
      round_time   <= TIME_LIMIT;
      r_presc      <= 6'd0;
      r_p1_latch   <= 1'b0;
      r_p2_latch   <= 1'b0;
      r_p1_hs_cnt  <= 5'd0;
      r_p1_bs_cnt  <= 5'd0;
      r_p2_hs_cnt  <= 5'd0;
      r_p2_bs_cnt  <= 5'd0;
      p1_hitstun   <= 1'b0;
      p1_blockstun <= 1'b0;
      p2_hitstun   <= 1'b0;
      p2_blockstun <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      play_active <= (w_state_nxt == S_PLAY);
      game_over   <= (w_state_nxt == S_OVER);
      r_p1_latch  <= (p1_state == 4'd6) && (r_p1_latch || w_p1_hit);
      r_p2_latch  <= (p2_state == 4'd6) && (r_p2_latch || w_p2_hit);
      // Entering or sitting in READY rearms the round; OVER only lets stun drain.
      if (w_state_nxt == S_READY) begin
        winner       <= 2'b00;
        p1_health    <= MAX_HEALTH;
        p2_health    <= MAX_HEALTH;
        round_time   <= TIME_LIMIT;
        r_presc      <= 6'd0;
        r_p1_hs_cnt  <= 5'd0;
        r_p1_bs_cnt  <= 5'd0;
        r_p2_hs_cnt  <= 5'd0;
        r_p2_bs_cnt  <= 5'd0;
        p1_hitstun   <= 1'b0;
        p1_blockstun <= 1'b0;
        p2_hitstun   <= 1'b0;
        p2_blockstun <= 1'b0;
      end else begin
        winner       <= w_winner_nxt;
        p1_health    <= w_p1_health_nxt;
        p2_health    <= w_p2_health_nxt;
        r_p1_hs_cnt  <= w_p1_hs_nxt;
        r_p1_bs_cnt  <= w_p1_bs_nxt;
        r_p2_hs_cnt  <= w_p2_hs_nxt;
        r_p2_bs_cnt  <= w_p2_bs_nxt;
        p1_hitstun   <= (w_p1_hs_nxt != 5'd0);
        p1_blockstun <= (w_p1_bs_nxt != 5'd0);
        p2_hitstun   <= (w_p2_hs_nxt != 5'd0);
        p2_blockstun <= (w_p2_bs_nxt != 5'd0);
        if (w_play) begin
          round_time <= w_time_nxt;
          r_presc    <= w_presc_nxt;
        end
      end
    end
  end

endmodule

// File: doc/combat_resolver.md
Name: combat_resolver

Overview:
- Downstream of both per-player movement/attack FSMs, on the 60 Hz game clock.
- Consumes each player's x position, FSM state code and attack-type flags.
- Decides hits vs. blocks, tracks health, hitstun/blockstun and the round timer, and declares the winner.
- Drives play_active back to both FSMs.

Parameters:
- MAX_HEALTH, 3, starting health per player (3-bit field).
- DMG_BASIC, 1, damage of a neutral attack (attacking=1).
- DMG_DIR, 2, damage of a directional attack (dir_attacking=1).
- REACH_BASIC, 10'd32, max pixel gap for a neutral hit.
- REACH_DIR, 10'd48, max pixel gap for a directional hit.
- SPRITE_W, 10'd64, sprite width in pixels.
- HITSTUN, 5'd16, hitstun length in frames.
- BLOCKSTUN, 5'd8, blockstun length in frames.
- TIME_LIMIT, 7'd99, round length in seconds.
- FRAMES_PER_SEC, 6'd60, prescaler period.

Ports:
- clk  in  1  60 Hz game clock, all flops on rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  level; starts a round from READY, returns OVER to READY.
- p1_x  in  10  left-player sprite left edge.
- p2_x  in  10  right-player sprite left edge.
- p1_state  in  4  P1 FSM state code.
- p2_state  in  4  P2 FSM state code.
- p1_attacking, p1_dir_attacking  in  1 each  P1 attack type flags.
- p2_attacking, p2_dir_attacking  in  1 each  P2 attack type flags.
- play_active  out  1  high only in PLAY.
- p1_health, p2_health  out  3 each  current health.
- p1_hitstun, p1_blockstun, p2_hitstun, p2_blockstun  out  1 each  stun flags.
- round_time  out  7  seconds remaining.
- game_over  out  1  high in OVER.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw.

Behaviour:
- State codes: 0 IDLE, 1 MOVE_FWD, 2 MOVE_BWD, 3 ATTACK, 4 DIR_ATTACK, 5 STARTUP, 6 ACTIVE, 7 RECOVERY.
- Reset (reset_n=0 at an edge): round FSM=READY, play_active=0, health=MAX_HEALTH, round_time=TIME_LIMIT, prescaler=0, stun counters/flags=0, hit latches=0, game_over=0, winner=00. Reset mid-round aborts everything to these values.
- Round FSM:
  - READY -> PLAY when start=1.
  - PLAY -> OVER on KO or timeout.
  - OVER -> READY when start=1; READY reloads health, time, stun and winner.
  - All outputs are registered; play_active is the registered decode of PLAY.
- Gap: gap = p2_x - p1_x - SPRITE_W, computed at 11 bits. If p2_x < p1_x + SPRITE_W, gap = 0.
- Hit check, PLAY only, per attacker:
  - Qualifies when attacker state == 6, the attacker's hit latch is 0, and gap <= reach.
  - Reach is REACH_DIR if dir_attacking=1, else REACH_BASIC. If both flags are 0, no hit.
  - On qualify, set the hit latch. One hit per attack; the latch clears when attacker state != 6.
- Block vs. hit on the defender:
  - Block when defender state == 2 and defender hitstun flag == 0: load blockstun counter with BLOCKSTUN, no damage.
  - Otherwise hit: health -= damage, saturating at 0; load hitstun counter with HITSTUN and clear blockstun.
  - A new hit/block while stunned reloads the counter.
- Stun counters decrement by 1 per clk while nonzero. Flag = counter != 0.
- Latency: the hit condition is sampled at edge t; health and stun update at edge t. Outputs are visible after edge t.
- Simultaneous hits: both resolve in the same cycle (trade).
- Timer: in PLAY the prescaler counts 0..FRAMES_PER_SEC-1. On wrap, round_time decrements. The timer freezes outside PLAY.
- End of round, evaluated on the same-cycle next values:
  - If either health becomes 0: KO -> OVER. Winner is the survivor, or 11 if both are 0.
  - Else if round_time becomes 0: timeout -> OVER. Winner is higher health, or 11 if equal.
  - KO takes priority over a simultaneous timeout.
- OVER: health, time and winner hold; no hits are evaluated; stun counters continue draining to 0.

Test Plan:
- Basic hit: reset, start; p1_x=100, p2_x=180 (gap 16), p1_state=6 with attacking=1 for 2 frames -> p2_health 3->2 once only; p2_hitstun high 16 frames.
- Block: same setup, p2_state=2 -> p2_health stays 3, p2_blockstun high 8 frames, p2_hitstun 0.
- Reach: gap 40, neutral attack -> no hit; same gap with dir_attacking=1 -> p2_health 3->1.
- Trade/draw: both at health 1, both in state 6 in range on the same frame -> both health 0, next cycle game_over=1, winner=11, play_active=0.
- Timeout: TIME_LIMIT=2, no attacks, p1 hit once earlier -> after 120 PLAY frames, game_over=1, winner=10.
- Reset mid-round: reset_n=0 during hitstun with health 2 -> all outputs at reset values after that edge; start required to replay.
